data_mem_stage: RTL and testbench

Multi-cycle data-memory stage of the pipelined CPU, between the EX/MEM pipeline register and the MEM/WB register. It performs byte, halfword and word loads and stores against an internal word-organised memory with configurable access latency. `stall_o` freezes the upstream pipeline while an access is in flight. `ReadData_o` is a sign- or zero-extended load result that the MEM/WB register captures.

---
 rtl/data_mem_stage.sv | 135 +++++++++++++
 tb/tb_data_mem_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - multi-cycle data-memory stage with byte/half/word loads and stores
// Word-organised little-endian array behind an IDLE/BUSY/DONE latency FSM.
module data_mem_stage #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [2:0]  Funct3_i,
   input  logic [31:0] Addr_i,
   input  logic [31:0] WriteData_i,
   output logic [31:0] ReadData_o,
   output logic        stall_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          wr_q;
   logic [2:0]    f3_q;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic [2:0]    ld_f3_q;
   logic [1:0]    ld_lane_q;
   logic [31:0]   mem [DEPTH];

   logic          req;
   logic          enter_done;
   logic          wr_sel;
   logic [2:0]    f3_sel;
   logic [AW+1:0] addr_sel;
   logic [31:0]   wdata_sel;
   logic [AW-1:0] idx_sel;
   logic [1:0]    lane_sel;
   logic [31:0]   old_word;
   logic [31:0]   merged;
   logic [7:0]    bsel;
   logic [15:0]   hsel;
   logic          unused_addr;

   assign req         = MemRead_i | MemWrite_i;
   assign stall_o     = req & (state != DONE);
   assign unused_addr = ^Addr_i[31:AW+2];

   // With LATENCY == 1 the commit happens on the accepting edge, so the live inputs are used in IDLE.
   assign wr_sel     = (state == IDLE) ? MemWrite_i  : wr_q;
   assign f3_sel     = (state == IDLE) ? Funct3_i    : f3_q;
   assign addr_sel   = (state == IDLE) ? Addr_i[AW+1:0] : addr_q;
   assign wdata_sel  = (state == IDLE) ? WriteData_i : wdata_q;
   assign idx_sel    = addr_sel[AW+1:2];
   assign lane_sel   = addr_sel[1:0];
   assign old_word   = mem[idx_sel];
   assign enter_done = ((state == IDLE) && req && (LATENCY == 1)) ||
                       ((state == BUSY) && (cnt == CW'(1)));

   always_comb begin
      merged = old_word;
      case (f3_sel[1:0])
         2'b00:   merged[{lane_sel, 3'b000} +: 8] = wdata_sel[7:0];
         2'b01: begin
            if (lane_sel[1]) merged[31:16] = wdata_sel[15:0];
            else             merged[15:0]  = wdata_sel[15:0];
         end
         default: merged = wdata_sel;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         wr_q      <= 1'b0;
         f3_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         ld_f3_q   <= '0;
         ld_lane_q <= '0;
      end else begin
         if (enter_done && !wr_sel) begin
            rdata_q   <= old_word;
            ld_f3_q   <= f3_sel;
            ld_lane_q <= lane_sel;
         end
         case (state)
            IDLE: begin
               if (req) begin
                  wr_q    <= MemWrite_i;
                  f3_q    <= Funct3_i;
                  addr_q  <= Addr_i[AW+1:0];
                  wdata_q <= WriteData_i;
                  if (LATENCY == 1) begin
                     cnt   <= CW'(LATENCY);
                     state <= DONE;
                  end else begin
                     cnt   <= CW'(LATENCY - 1);
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (cnt == CW'(1)) state <= DONE;
               else               cnt   <= cnt - CW'(1);
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The array is deliberately not reset; a store aborted by reset never reaches it.
   always_ff @(posedge clk_i) begin
      if (!rst_i && enter_done && wr_sel) mem[idx_sel] <= merged;
   end

   always_comb begin
      bsel = rdata_q[{ld_lane_q, 3'b000} +: 8];
      hsel = ld_lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (ld_f3_q)
         3'b000:  ReadData_o = {{24{bsel[7]}}, bsel};
         3'b001:  ReadData_o = {{16{hsel[15]}}, hsel};
         3'b100:  ReadData_o = {24'h0, bsel};
         3'b101:  ReadData_o = {16'h0, hsel};
         default: ReadData_o = rdata_q;
      endcase
   end
endmodule

// File: tb/tb_data_mem_stage.sv
// tb/tb_data_mem_stage.sv - directed bench for data_mem_stage at LATENCY 2, 1 and 4
// Instance 0: LATENCY 2, instance 1: LATENCY 1, instance 2: LATENCY 4.
module tb_data_mem_stage;
   logic        clk = 1'b0;
   logic        rst       [3];
   logic        mem_read  [3];
   logic        mem_write [3];
   logic [2:0]  funct3    [3];
   logic [31:0] addr      [3];
   logic [31:0] wdata     [3];
   logic [31:0] rdata     [3];
   logic        stall     [3];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      data_mem_stage #(.DEPTH(256), .LATENCY(LAT)) u_dut (
         .clk_i      (clk),
         .rst_i      (rst[g]),
         .MemRead_i  (mem_read[g]),
         .MemWrite_i (mem_write[g]),
         .Funct3_i   (funct3[g]),
         .Addr_i     (addr[g]),
         .WriteData_i(wdata[g]),
         .ReadData_o (rdata[g]),
         .stall_o    (stall[g])
      );
   end

   function automatic int lat(input int k);
      return (k == 0) ? 2 : (k == 1) ? 1 : 4;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge with the instance in IDLE; returns just after the edge ending DONE.
   task automatic op(input int k, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic chk, input logic [31:0] exp, input string tag);
      mem_read[k] = rd; mem_write[k] = wr; funct3[k] = f3; addr[k] = a; wdata[k] = wd;
      for (int c = 0; c < lat(k); c++) begin
         @(negedge clk);
         check($sformatf("%s_stall%0d", tag, c), {31'h0, stall[k]}, 32'h1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check($sformatf("%s_done_stall", tag), {31'h0, stall[k]}, 32'h0);
      if (chk) check($sformatf("%s_rdata", tag), rdata[k], exp);
      @(posedge clk); #1;
      mem_read[k] = 1'b0; mem_write[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; mem_read[k] = 1'b0; mem_write[k] = 1'b0;
         funct3[k] = 3'b0; addr[k] = 32'h0; wdata[k] = 32'h0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;

      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("idle_stall%0d", c), {31'h0, stall[0]}, 32'h0);
         check($sformatf("idle_rdata%0d", c), rdata[0], 32'h0);
      end
      check("idle_rdata_l1", rdata[1], 32'h0);
      check("idle_rdata_l4", rdata[2], 32'h0);
      @(posedge clk); #1;

      // LATENCY 2: word, sub-word, extension and wrap
      op(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 32'h0,        "sw_10");
      op(0, 1, 0, 3'b010, 32'h10, 32'h0,        1, 32'hDEADBEEF, "lw_10");
      op(0, 0, 1, 3'b010, 32'h20, 32'h0,        1, 32'hDEADBEEF, "sw_20");
      op(0, 0, 1, 3'b000, 32'h22, 32'h12345680, 1, 32'hDEADBEEF, "sb_22");
      op(0, 0, 1, 3'b001, 32'h20, 32'hABCDFFFE, 1, 32'hDEADBEEF, "sh_20");
      op(0, 1, 0, 3'b010, 32'h20, 32'h0,        1, 32'h0080FFFE, "lw_20");
      op(0, 1, 0, 3'b000, 32'h22, 32'h0,        1, 32'hFFFFFF80, "lb_22");
      op(0, 1, 0, 3'b100, 32'h22, 32'h0,        1, 32'h00000080, "lbu_22");
      op(0, 1, 0, 3'b001, 32'h20, 32'h0,        1, 32'hFFFFFFFE, "lh_20");
      op(0, 1, 0, 3'b101, 32'h20, 32'h0,        1, 32'h0000FFFE, "lhu_20");
      op(0, 1, 0, 3'b101, 32'h23, 32'h0,        1, 32'h00000080, "lhu_23");
      op(0, 1, 0, 3'b000, 32'h23, 32'h0,        1, 32'h00000000, "lb_23");
      op(0, 1, 0, 3'b111, 32'h21, 32'h0,        1, 32'h0080FFFE, "lw111_21");
      op(0, 1, 1, 3'b010, 32'h24, 32'h5555AAAA, 0, 32'h0,        "rdwr_24");
      op(0, 1, 0, 3'b010, 32'h24, 32'h0,        1, 32'h5555AAAA, "lw_24");
      op(0, 0, 1, 3'b010, 32'h400, 32'h12345678, 1, 32'h5555AAAA, "sw_400");
      op(0, 1, 0, 3'b010, 32'h000, 32'h0,        1, 32'h12345678, "lw_000");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("nomem_stall%0d", c), {31'h0, stall[0]}, 32'h0);
         check($sformatf("nomem_rdata%0d", c), rdata[0], 32'h12345678);
      end
      @(posedge clk); #1;

      // LATENCY 1
      op(1, 0, 1, 3'b010, 32'h44, 32'hCAFEF00D, 1, 32'h0,        "l1_sw_44");
      op(1, 1, 0, 3'b010, 32'h44, 32'h0,        1, 32'hCAFEF00D, "l1_lw_44");
      op(1, 0, 1, 3'b000, 32'h45, 32'h00000011, 1, 32'hCAFEF00D, "l1_sb_45");
      op(1, 1, 0, 3'b010, 32'h44, 32'h0,        1, 32'hCAFE110D, "l1_lw_44b");

      // LATENCY 4, then a store aborted by reset in its second BUSY cycle
      op(2, 0, 1, 3'b010, 32'h30, 32'h11111111, 1, 32'h0,        "l4_sw_30");
      op(2, 1, 0, 3'b010, 32'h30, 32'h0,        1, 32'h11111111, "l4_lw_30");
      mem_write[2] = 1'b1; funct3[2] = 3'b010; addr[2] = 32'h30; wdata[2] = 32'hAAAAAAAA;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst[2] = 1'b1; mem_write[2] = 1'b0;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      @(negedge clk);
      check("rst_mid_stall", {31'h0, stall[2]}, 32'h0);
      check("rst_mid_rdata", rdata[2], 32'h0);
      @(posedge clk); #1;
      op(2, 1, 0, 3'b010, 32'h30, 32'h0, 1, 32'h11111111, "l4_lw_30_after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
